fc_argmax_stream: RTL

- Streaming arg-max classifier, directly downstream of the fully-connected layer (M=10 outputs, T=16-bit signed).
- Consumes one M-element output vector per inference over a valid/ready stream.
- Returns the index and value of the largest element over the same handshake protocol.
- Final stage before the host readout.

---
 rtl/fc_argmax_stream_if.sv | 25 ++
 rtl/fc_argmax_stream.sv | 78 +++++++
 2 files changed

// File: rtl/fc_argmax_stream_if.sv
// rtl/fc_argmax_stream_if.sv - element input stream and result output stream for the arg-max stage
interface fc_argmax_stream_if #(
  parameter int M = 10,
  parameter int T = 16
);
  localparam int IW = $clog2(M);

  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic [IW-1:0]       output_index;
  logic signed [T-1:0] output_max;

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_index, output_max
  );

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_index, output_max
  );
endinterface

// File: rtl/fc_argmax_stream.sv
// rtl/fc_argmax_stream.sv - streaming arg-max over M-element signed vectors
module fc_argmax_stream #(
  parameter int M = 10,
  parameter int T = 16
) (
  input logic               clk,
  input logic               reset,
  fc_argmax_stream_if.slave bus
);
  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] LAST = IW'(M - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic signed [T-1:0] max_q, max_d;
  logic                accept;
  logic                transfer;

  assign accept   = bus.input_valid & bus.input_ready;
  assign transfer = bus.output_valid & bus.output_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
    end
  end

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    max_d   = max_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == '0) begin
            max_d = bus.input_data;
            idx_d = '0;
          end else if (bus.input_data > max_q) begin
            max_d = bus.input_data;
            idx_d = cnt_q;
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (transfer) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    bus.input_ready  = reset && (state_q == COLLECT);
    bus.output_valid = reset && (state_q == HOLD);
    bus.output_index = reset ? idx_q : '0;
    bus.output_max   = reset ? max_q : '0;
  end
endmodule
